// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared types and constants for the bit-serial adder.
//   state_t : controller state encoding (IDLE / RUN / DONE)
//   SERIAL_ADDER_DEFAULT_WIDTH : default operand width
//   cnt_width() : bit-counter width for a given operand width, never below 1
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SERIAL_ADDER_DEFAULT_WIDTH = 8;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/and_gate.sv
// and_gate
//   Two-input AND primitive.
//   a_i, b_i : inputs
//   y_o      : a_i & b_i
module and_gate (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);
  assign y_o = a_i & b_i;
endmodule

// File: rtl/fa_cell.sv
// fa_cell
//   Purely combinational 1-bit full adder built from gate primitives.
//   a_i, b_i : operand bits
//   ci_i     : carry in
//   s_o      : a ^ b ^ ci
//   co_o     : (a & b) | (ci & (a ^ b))
module fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);
  logic p;   // propagate
  logic g;   // generate
  logic pc;  // carry passed through the propagate path

  xor_gate u_xor_p  (.a_i(a_i),  .b_i(b_i),  .y_o(p));
  xor_gate u_xor_s  (.a_i(p),    .b_i(ci_i), .y_o(s_o));
  and_gate u_and_g  (.a_i(a_i),  .b_i(b_i),  .y_o(g));
  and_gate u_and_pc (.a_i(p),    .b_i(ci_i), .y_o(pc));
  or_gate  u_or_co  (.a_i(g),    .b_i(pc),   .y_o(co_o));
endmodule

// File: rtl/or_gate.sv
// or_gate
//   Two-input OR primitive.
//   a_i, b_i : inputs
//   y_o      : a_i | b_i
module or_gate (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);
  assign y_o = a_i | b_i;
endmodule

// File: rtl/xor_gate.sv
// xor_gate
//   Two-input XOR primitive.
//   a_i, b_i : inputs
//   y_o      : a_i ^ b_i
module xor_gate (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);
  assign y_o = a_i ^ b_i;
endmodule

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial WIDTH-bit adder. Operands are taken over an input valid/ready
//   handshake, rippled LSB-first through one fa_cell (one bit per clock, carry
//   held in a flip-flop), and the result is offered over an output handshake.
//
//   Handshake rule (both sides): a transfer happens on a rising edge where
//   valid and ready are both 1. in_ready is 1 only in IDLE and out_valid only
//   in DONE; both are decoded from registered state, so neither depends
//   combinationally on any input. Once out_valid is up, sum/cout hold until
//   out_ready is seen.
//
//   Ports:
//     clk, rst        : clock, synchronous active-high reset
//     in_valid/ready  : operand handshake
//     in1, in2, cin   : operands and carry-in
//     out_valid/ready : result handshake
//     sum, cout       : (in1 + in2 + cin) mod 2^WIDTH and its carry-out
//     dbg_state_o     : current controller state, for observation
//
//   Optional build macro SERIAL_ADDER_SUB_EN adds input `sub`: when 1 at
//   acceptance, B is inverted and carry-in forced to 1 (sum = in1 - in2,
//   cout = 1 means no borrow).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SERIAL_ADDER_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output state_t           dbg_state_o
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic             fa_s, fa_co;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

`ifdef SERIAL_ADDER_SUB_EN
  // Subtraction as A + ~B + 1; cin is irrelevant in that mode.
  assign b_load = sub ? ~in2 : in2;
  assign c_load = sub ? 1'b1 : cin;
`else
  assign b_load = in2;
  assign c_load = cin;
`endif

  fa_cell u_fa (
    .a_i (a_q[0]),
    .b_i (b_q[0]),
    .ci_i(carry_q),
    .s_o (fa_s),
    .co_o(fa_co)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in1;
          b_d     = b_load;
          carry_d = c_load;
          sum_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at LSB.
        sum_d            = sum_q >> 1;
        sum_d[WIDTH-1]   = fa_s;
        a_d              = a_q >> 1;
        b_d              = b_q >> 1;
        carry_d          = fa_co;
        cnt_d            = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          cout_d  = fa_co;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign sum         = sum_q;
  assign cout        = cout_q;
  assign dbg_state_o = state_q;

endmodule
